// File: rtl/cpc_ga_pkg.sv
// Shared constants for the Gate Array sync/interrupt slice.
// Holds the default sync timing, the R52 terminal count, the RMR bit positions
// and the widths of the internal counters.
package cpc_ga_pkg;

  // Default sync shaping and interrupt timing
  localparam int unsigned HS_DELAY_DEF  = 2;
  localparam int unsigned HS_WIDTH_DEF  = 4;
  localparam int unsigned VS_DELAY_DEF  = 2;
  localparam int unsigned VS_WIDTH_DEF  = 4;
  localparam int unsigned INT_LINES_DEF = 52;

  // RMR data bit positions
  localparam int unsigned RMR_CLR_BIT  = 4;
  localparam int unsigned RMR_MODE_LSB = 0;

  // Datapath widths
  localparam int unsigned MODE_W = 2;
  localparam int unsigned R52_W  = 6;
  localparam int unsigned HCNT_W = 4;
  localparam int unsigned VCNT_W = 3;

  typedef logic [MODE_W-1:0] mode_t;
  typedef logic [R52_W-1:0]  r52_t;

endpackage

// File: rtl/ga_sync_shaper.sv
// Generic delay/width pulse shaper.
// A start event clears the step counter and arms the shaper; each step while
// armed advances a saturating counter; a stop event disarms it. The registered
// pulse is high while armed and DELAY <= count < DELAY+WIDTH.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        (re)start the delay count
//   step_i         advance the count by one
//   stop_i         end of the source pulse
//   pulse_o        shaped pulse (registered)
//   delay_hit_o_c  step that brings the count to DELAY (combinational)
module ga_sync_shaper #(
  parameter int unsigned DELAY = 2,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic step_i,
  input  logic stop_i,
  output logic pulse_o,
  output logic delay_hit_o_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             pulse_d;

  // Next-state: start beats stop beats step
  always_comb begin
    cnt_d         = cnt_q;
    act_d         = act_q;
    delay_hit_o_c = 1'b0;
    if (start_i) begin
      cnt_d = '0;
      act_d = 1'b1;
    end else if (stop_i) begin
      act_d = 1'b0;
    end else if (step_i && act_q) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d         = cnt_q + CNT_W'(1);
        delay_hit_o_c = (32'(cnt_d) == DELAY);
      end
    end
    pulse_d = act_d && (32'(cnt_d) >= DELAY) && (32'(cnt_d) < (DELAY + WIDTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      act_q   <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pulse_o <= pulse_d;
    end
  end

endmodule

// File: rtl/ga_sync_int.sv
// Gate Array sync and interrupt generator.
// Samples the CRTC syncs on the character enable, shapes the monitor
// HSYNC/VSYNC, runs the 52-line interrupt counter and applies the RMR mode at
// the start of each HSYNC.
// Ports:
//   CLOCK, RESET      clock, synchronous active-high reset
//   CLKEN             character clock enable
//   HSYNC_I, VSYNC_I  CRTC syncs
//   INT_ACK           Z80 interrupt acknowledge pulse
//   RMR_WR, DI        RMR write strobe and data (bit4 clear R52, bits1:0 mode)
//   INT               interrupt request
//   HSYNC_O, VSYNC_O  monitor syncs
//   MODE              active screen mode
//   R52               line counter
module ga_sync_int
  import cpc_ga_pkg::*;
#(
  parameter int unsigned HS_DELAY  = HS_DELAY_DEF,
  parameter int unsigned HS_WIDTH  = HS_WIDTH_DEF,
  parameter int unsigned VS_DELAY  = VS_DELAY_DEF,
  parameter int unsigned VS_WIDTH  = VS_WIDTH_DEF,
  parameter int unsigned INT_LINES = INT_LINES_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  input  logic       INT_ACK,
  input  logic       RMR_WR,
  input  logic [7:0] DI,
  output logic       INT,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic [1:0] MODE,
  output logic [5:0] R52
);

  logic  smp_vld_q, hs_q, vs_q;
  logic  hs_rise_c, hs_fall_c, vs_rise_c;
  logic  vs_hit_c, hs_hit_unused;
  logic  rmr_clr_c;
  logic  int_q, int_d, int_set;
  r52_t  r52_q, r52_d, r52_inc;
  mode_t pend_q, pend_d, mode_q, mode_d;

  // Edges only count once a post-reset sample exists, so a sync already high
  // out of reset is ignored until its next rise.
  assign hs_rise_c = CLKEN & smp_vld_q &  HSYNC_I & ~hs_q;
  assign hs_fall_c = CLKEN & smp_vld_q & ~HSYNC_I &  hs_q;
  assign vs_rise_c = CLKEN & smp_vld_q &  VSYNC_I & ~vs_q;
  assign rmr_clr_c = RMR_WR & DI[RMR_CLR_BIT];

  // Monitor HSYNC: counts characters while the CRTC HSYNC is high
  ga_sync_shaper #(
    .DELAY (HS_DELAY),
    .WIDTH (HS_WIDTH),
    .CNT_W (HCNT_W)
  ) u_hs_shaper (
    .clk_i         (CLOCK),
    .rst_i         (RESET),
    .start_i       (hs_rise_c),
    .step_i        (CLKEN & HSYNC_I),
    .stop_i        (CLKEN & ~HSYNC_I),
    .pulse_o       (HSYNC_O),
    .delay_hit_o_c (hs_hit_unused)
  );

  // Monitor VSYNC: counts HSYNC falls while the CRTC VSYNC is high
  ga_sync_shaper #(
    .DELAY (VS_DELAY),
    .WIDTH (VS_WIDTH),
    .CNT_W (VCNT_W)
  ) u_vs_shaper (
    .clk_i         (CLOCK),
    .rst_i         (RESET),
    .start_i       (vs_rise_c),
    .step_i        (hs_fall_c),
    .stop_i        (CLKEN & ~VSYNC_I),
    .pulse_o       (VSYNC_O),
    .delay_hit_o_c (vs_hit_c)
  );

  // R52 / INT / mode next-state; later assignments take priority
  always_comb begin
    r52_d   = r52_q;
    int_set = 1'b0;
    r52_inc = r52_q + R52_W'(1);
    if (hs_fall_c) begin
      if (vs_hit_c) begin
        int_set = (r52_q >= R52_W'(32));
        r52_d   = '0;
      end else if (r52_inc == R52_W'(INT_LINES)) begin
        int_set = 1'b1;
        r52_d   = '0;
      end else begin
        r52_d = r52_inc;
      end
    end
    // A new request in the same cycle as an ack survives the ack
    int_d = (int_q & ~INT_ACK) | int_set;
    if (INT_ACK) begin
      r52_d[R52_W-1] = 1'b0;
    end
    if (rmr_clr_c) begin
      r52_d = '0;
      int_d = 1'b0;
    end
    pend_d = RMR_WR ? DI[RMR_MODE_LSB +: MODE_W] : pend_q;
    mode_d = hs_rise_c ? pend_d : mode_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      smp_vld_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      int_q     <= 1'b0;
      r52_q     <= '0;
      pend_q    <= '0;
      mode_q    <= '0;
    end else begin
      if (CLKEN) begin
        smp_vld_q <= 1'b1;
        hs_q      <= HSYNC_I;
        vs_q      <= VSYNC_I;
      end
      int_q  <= int_d;
      r52_q  <= r52_d;
      pend_q <= pend_d;
      mode_q <= mode_d;
    end
  end

  assign INT  = int_q;
  assign R52  = r52_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_ga_sync_int.sv
// Bench for ga_sync_int: directed scenarios plus randomized traffic compared
// against an event-level model of the sync/interrupt rules.
module tb_ga_sync_int;

  localparam int HS_DELAY  = 2;
  localparam int HS_WIDTH  = 4;
  localparam int VS_DELAY  = 2;
  localparam int VS_WIDTH  = 4;
  localparam int INT_LINES = 52;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLKEN = 1'b0;
  logic       HSYNC_I = 1'b0;
  logic       VSYNC_I = 1'b0;
  logic       INT_ACK = 1'b0;
  logic       RMR_WR = 1'b0;
  logic [7:0] DI = 8'h00;
  logic       INT, HSYNC_O, VSYNC_O;
  logic [1:0] MODE;
  logic [5:0] R52;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state
  bit       m_vld = 0, m_phs = 0, m_pvs = 0;
  int       m_hch = -1;   // chars since HSYNC_I rise, -1 when none
  int       m_vfl = -1;   // HSYNC falls since VSYNC_I rise, -1 when none
  bit       m_int = 0, m_hso = 0, m_vso = 0;
  int       m_r52 = 0;
  bit [1:0] m_mode = 0, m_pend = 0;

  ga_sync_int dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .CLKEN   (CLKEN),
    .HSYNC_I (HSYNC_I),
    .VSYNC_I (VSYNC_I),
    .INT_ACK (INT_ACK),
    .RMR_WR  (RMR_WR),
    .DI      (DI),
    .INT     (INT),
    .HSYNC_O (HSYNC_O),
    .VSYNC_O (VSYNC_O),
    .MODE    (MODE),
    .R52     (R52)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run time exceeded, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  // One CLOCK of the reference behaviour, applied with the inputs of that cycle
  task automatic model_step(input logic rst, ce, hs, vs, ack, wr, input logic [7:0] di);
    bit hr, hf, vr, vhit, set;
    if (rst) begin
      m_vld = 0; m_phs = 0; m_pvs = 0; m_hch = -1; m_vfl = -1;
      m_int = 0; m_hso = 0; m_vso = 0; m_r52 = 0; m_mode = 0; m_pend = 0;
      return;
    end
    hr = ce && m_vld && hs && !m_phs;
    hf = ce && m_vld && !hs && m_phs;
    vr = ce && m_vld && vs && !m_pvs;
    vhit = 0;
    set  = 0;
    if (ce) begin
      if (hr) m_hch = 0;
      else if (!hs) m_hch = -1;
      else if (m_hch >= 0) m_hch++;
      m_hso = (m_hch >= HS_DELAY) && (m_hch < HS_DELAY + HS_WIDTH);
      if (vr) m_vfl = 0;
      else if (!vs) m_vfl = -1;
      else if (hf && m_vfl >= 0) begin
        m_vfl++;
        vhit = (m_vfl == VS_DELAY);
      end
      m_vso = (m_vfl >= VS_DELAY) && (m_vfl < VS_DELAY + VS_WIDTH);
      m_phs = hs; m_pvs = vs; m_vld = 1;
    end
    if (hf) begin
      if (vhit) begin
        set   = (m_r52 >= 32);
        m_r52 = 0;
      end else begin
        m_r52++;
        if (m_r52 == INT_LINES) begin
          m_r52 = 0;
          set   = 1;
        end
      end
    end
    m_int = (m_int && !ack) || set;
    if (ack) m_r52 = m_r52 % 32;
    if (wr && di[4]) begin
      m_r52 = 0;
      m_int = 0;
    end
    if (hr) m_mode = wr ? di[1:0] : m_pend;
    if (wr) m_pend = di[1:0];
  endtask

  task automatic tick(input logic rst, ce, hs, vs, ack, wr, input logic [7:0] di);
    RESET = rst; CLKEN = ce; HSYNC_I = hs; VSYNC_I = vs;
    INT_ACK = ack; RMR_WR = wr; DI = di;
    @(posedge CLOCK);
    model_step(rst, ce, hs, vs, ack, wr, di);
    #1;
  endtask

  // One character: CLKEN on the first of four CLOCKs
  task automatic char_t(input logic hs, input logic vs);
    tick(1'b0, 1'b1, hs, vs, 1'b0, 1'b0, 8'h00);
    repeat (3) tick(1'b0, 1'b0, hs, vs, 1'b0, 1'b0, 8'h00);
  endtask

  // One scan line: 4 chars of HSYNC, then the fall char (optional RMR write on it)
  task automatic line_t(input logic vs, input logic wr, input logic [7:0] di);
    repeat (4) char_t(1'b1, vs);
    tick(1'b0, 1'b1, 1'b0, vs, 1'b0, wr, di);
    repeat (3) tick(1'b0, 1'b0, 1'b0, vs, 1'b0, 1'b0, 8'h00);
    repeat (3) char_t(1'b0, vs);
  endtask

  task automatic do_reset();
    repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) char_t(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    n_chk++; if (INT !== 1'b0) $display("FAIL reset_int: got %b want 0", INT); else n_pass++;
    n_chk++; if (HSYNC_O !== 1'b0) $display("FAIL reset_hs: got %b want 0", HSYNC_O); else n_pass++;
    n_chk++; if (VSYNC_O !== 1'b0) $display("FAIL reset_vs: got %b want 0", VSYNC_O); else n_pass++;
    n_chk++; if (MODE !== 2'd0) $display("FAIL reset_mode: got %0d want 0", MODE); else n_pass++;
    n_chk++; if (R52 !== 6'd0) $display("FAIL reset_r52: got %0d want 0", R52); else n_pass++;
    repeat (2) char_t(1'b0, 1'b0);
  endtask

  task automatic test_hsync_width();
    int lens[4] = '{14, 4, 2, 3};
    foreach (lens[j]) begin
      int cnt = 0;
      int first = -1;
      int exp_cnt;
      for (int k = 0; k < lens[j] + 4; k++) begin
        char_t(k < lens[j], 1'b0);
        if (HSYNC_O === 1'b1) begin
          if (first < 0) first = k;
          cnt++;
        end
      end
      exp_cnt = lens[j] - HS_DELAY;
      if (exp_cnt < 0) exp_cnt = 0;
      if (exp_cnt > HS_WIDTH) exp_cnt = HS_WIDTH;
      n_chk++;
      if (cnt !== exp_cnt) $display("FAIL hs_width len=%0d: got %0d chars want %0d", lens[j], cnt, exp_cnt);
      else n_pass++;
      if (exp_cnt > 0) begin
        n_chk++;
        if (first !== HS_DELAY) $display("FAIL hs_start len=%0d: got char %0d want %0d", lens[j], first, HS_DELAY);
        else n_pass++;
      end
    end
  endtask

  task automatic test_int_lines();
    do_reset();
    for (int i = 1; i <= 2 * INT_LINES; i++) begin
      line_t(1'b0, 1'b0, 8'h00);
      n_chk++;
      if (R52 !== 6'(i % INT_LINES)) $display("FAIL int_r52 line %0d: got %0d want %0d", i, R52, i % INT_LINES);
      else n_pass++;
      n_chk++;
      if (INT !== (i >= INT_LINES)) $display("FAIL int_req line %0d: got %b want %b", i, INT, i >= INT_LINES);
      else n_pass++;
    end
  endtask

  task automatic test_int_ack();
    repeat (40) line_t(1'b0, 1'b0, 8'h00);
    n_chk++; if (R52 !== 6'd40) $display("FAIL ack_pre_r52: got %0d want 40", R52); else n_pass++;
    n_chk++; if (INT !== 1'b1) $display("FAIL ack_pre_int: got %b want 1", INT); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_chk++; if (INT !== 1'b0) $display("FAIL ack_int: got %b want 0", INT); else n_pass++;
    n_chk++; if (R52 !== 6'd8) $display("FAIL ack_r52: got %0d want 8", R52); else n_pass++;
  endtask

  task automatic test_vsync(input int start);
    int vcnt = 0;
    bit exp_int = (start >= 32);
    do_reset();
    repeat (start) line_t(1'b0, 1'b0, 8'h00);
    n_chk++; if (R52 !== 6'(start)) $display("FAIL vs_pre_r52: got %0d want %0d", R52, start); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      line_t(1'b1, 1'b0, 8'h00);
      if (VSYNC_O === 1'b1) vcnt++;
      if (i == VS_DELAY) begin
        n_chk++; if (R52 !== 6'd0) $display("FAIL vs_r52 start=%0d: got %0d want 0", start, R52); else n_pass++;
        n_chk++; if (INT !== exp_int) $display("FAIL vs_int start=%0d: got %b want %b", start, INT, exp_int); else n_pass++;
        n_chk++; if (VSYNC_O !== 1'b1) $display("FAIL vs_rise start=%0d: got %b want 1", start, VSYNC_O); else n_pass++;
      end
    end
    n_chk++; if (vcnt !== VS_WIDTH) $display("FAIL vs_width: got %0d lines want %0d", vcnt, VS_WIDTH); else n_pass++;
    line_t(1'b0, 1'b0, 8'h00);
    n_chk++; if (VSYNC_O !== 1'b0) $display("FAIL vs_end: got %b want 0", VSYNC_O); else n_pass++;
  endtask

  task automatic test_rmr_clear();
    do_reset();
    repeat (INT_LINES - 1) line_t(1'b0, 1'b0, 8'h00);
    line_t(1'b0, 1'b1, 8'h12);
    n_chk++; if (INT !== 1'b0) $display("FAIL rmr_int: got %b want 0", INT); else n_pass++;
    n_chk++; if (R52 !== 6'd0) $display("FAIL rmr_r52: got %0d want 0", R52); else n_pass++;
    n_chk++; if (MODE !== 2'd0) $display("FAIL rmr_mode_hold: got %0d want 0", MODE); else n_pass++;
    char_t(1'b1, 1'b0);
    n_chk++; if (MODE !== 2'd2) $display("FAIL rmr_mode_apply: got %0d want 2", MODE); else n_pass++;
    char_t(1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
    n_chk++; if (MODE !== 2'd3) $display("FAIL rmr_mode_same_clk: got %0d want 3", MODE); else n_pass++;
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    char_t(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    do_reset();
    repeat (INT_LINES) line_t(1'b0, 1'b0, 8'h00);
    repeat (3) char_t(1'b1, 1'b0);
    n_chk++; if (INT !== 1'b1) $display("FAIL rmid_pre_int: got %b want 1", INT); else n_pass++;
    n_chk++; if (HSYNC_O !== 1'b1) $display("FAIL rmid_pre_hs: got %b want 1", HSYNC_O); else n_pass++;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_chk++; if (INT !== 1'b0) $display("FAIL rmid_int: got %b want 0", INT); else n_pass++;
    n_chk++; if (HSYNC_O !== 1'b0) $display("FAIL rmid_hs: got %b want 0", HSYNC_O); else n_pass++;
    n_chk++; if (VSYNC_O !== 1'b0) $display("FAIL rmid_vs: got %b want 0", VSYNC_O); else n_pass++;
    n_chk++; if (MODE !== 2'd0) $display("FAIL rmid_mode: got %0d want 0", MODE); else n_pass++;
    n_chk++; if (R52 !== 6'd0) $display("FAIL rmid_r52: got %0d want 0", R52); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      char_t(1'b1, 1'b0);
      if (HSYNC_O === 1'b1) cnt++;
    end
    n_chk++; if (cnt !== 0) $display("FAIL rmid_no_hs: got %0d chars want 0", cnt); else n_pass++;
    char_t(1'b0, 1'b0);
    repeat (3) char_t(1'b1, 1'b0);
    n_chk++; if (HSYNC_O !== 1'b1) $display("FAIL rmid_next_hs: got %b want 1", HSYNC_O); else n_pass++;
    char_t(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic hs = 1'b0;
    logic vs = 1'b0;
    do_reset();
    for (int n = 0; n < 8000; n++) begin
      logic ce, ack, wr, rst;
      logic [7:0] di;
      ce  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) hs = ~hs;
      if ($urandom_range(0, 199) == 0) vs = ~vs;
      ack = ($urandom_range(0, 99) == 0);
      wr  = ($urandom_range(0, 599) == 0);
      rst = ($urandom_range(0, 3999) == 0);
      di  = 8'($urandom);
      tick(rst, ce, hs, vs, ack, wr, di);
      n_chk++; if (INT !== m_int) $display("FAIL rnd_int @%0d: got %b want %b", n, INT, m_int); else n_pass++;
      n_chk++; if (HSYNC_O !== m_hso) $display("FAIL rnd_hs @%0d: got %b want %b", n, HSYNC_O, m_hso); else n_pass++;
      n_chk++; if (VSYNC_O !== m_vso) $display("FAIL rnd_vs @%0d: got %b want %b", n, VSYNC_O, m_vso); else n_pass++;
      n_chk++; if (MODE !== m_mode) $display("FAIL rnd_mode @%0d: got %0d want %0d", n, MODE, m_mode); else n_pass++;
      n_chk++; if (R52 !== 6'(m_r52)) $display("FAIL rnd_r52 @%0d: got %0d want %0d", n, R52, m_r52); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hsync_width();
    test_int_lines();
    test_int_ack();
    test_vsync(35);
    test_vsync(20);
    test_rmr_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
